// File: rtl/oam_dma_arbiter_pkg.sv
// Shared definitions for the OAM DMA arbiter.
//   dma_state_t  : engine state encoding (IDLE / START / ACTIVE)
//   constants    : register address, OAM base, hi-port base, transfer length,
//                  trigger-to-first-byte delay
//   src_hi_map() : maps the DMA register value to the source page
package oam_dma_arbiter_pkg;

   typedef enum logic [1:0] {
      DMA_IDLE   = 2'd0,
      DMA_START  = 2'd1,
      DMA_ACTIVE = 2'd2
   } dma_state_t;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] HI_BASE      = 16'hFF00;
   localparam int          DMA_LEN      = 160;
   localparam int          START_DELAY  = 4;

   localparam logic [7:0]  LAST_INDEX   = 8'(DMA_LEN - 1);
   localparam logic [2:0]  LAST_DELAY   = 3'(START_DELAY - 1);

   // Pages 0xE0-0xFF alias down by 0x20 (echo RAM), so the engine never
   // sources from the OAM / I/O region itself.
   function automatic logic [7:0] src_hi_map(input logic [7:0] dma_reg);
      return (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;
   endfunction

endpackage

// File: rtl/oam_dma_arbiter_engine.sv
// OAM DMA engine: trigger detection, START delay, per-byte read/write
// sequencing and the byte buffer. Produces ext-port requests only; the top
// level decides who owns the ext port.
//   clk, reset              : clock, synchronous active-low reset
//   cpu_write_en, reg_sel   : CPU write strobe, CPU address hits the DMA register
//   cpu_wdata               : CPU write data (new DMA register value)
//   ext_rdata               : main-space read data (source byte)
//   dma_reg                 : current DMA register value (CPU readback)
//   dma_active              : high exactly while in ACTIVE
//   dma_addr/dma_wdata      : ext-port address / write data requested by DMA
//   dma_read_en/dma_write_en: ext-port strobes requested by DMA
module oam_dma_engine
   import oam_dma_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_write_en,
   input  logic        reg_sel,
   input  logic [7:0]  cpu_wdata,
   input  logic [7:0]  ext_rdata,
   output logic [7:0]  dma_reg,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_wdata,
   output logic        dma_read_en,
   output logic        dma_write_en
);

   dma_state_t state_q, state_d;
   logic [7:0] dma_reg_q, dma_reg_d;
   logic [7:0] index_q, index_d;
   logic [1:0] phase_q, phase_d;
   logic [2:0] delay_q, delay_d;
   logic [7:0] buf_q, buf_d;
   logic       write_en_q, write_en_d;
   logic       trigger;

   // Rising edge of the write strobe only, so a held strobe fires once.
   assign trigger = cpu_write_en && !write_en_q && reg_sel;

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= DMA_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dma_reg_q  <= 8'h00;
         index_q    <= 8'h00;
         phase_q    <= 2'd0;
         delay_q    <= 3'd0;
         buf_q      <= 8'h00;
         write_en_q <= 1'b0;
      end else begin
         dma_reg_q  <= dma_reg_d;
         index_q    <= index_d;
         phase_q    <= phase_d;
         delay_q    <= delay_d;
         buf_q      <= buf_d;
         write_en_q <= write_en_d;
      end
   end

   // Next-state and counter logic. A trigger in any state restarts.
   always_comb begin
      // NOTE: every signal gets a default here so no path infers a latch.
      state_d    = state_q;
      dma_reg_d  = dma_reg_q;
      index_d    = index_q;
      phase_d    = phase_q;
      delay_d    = delay_q;
      buf_d      = buf_q;
      write_en_d = cpu_write_en;

      if (trigger) begin
         dma_reg_d = cpu_wdata;
         state_d   = DMA_START;
         delay_d   = 3'd0;
         index_d   = 8'h00;
         phase_d   = 2'd0;
      end else begin
         case (state_q)
            DMA_START: begin
               if (delay_q == LAST_DELAY) begin
                  state_d = DMA_ACTIVE;
                  index_d = 8'h00;
                  phase_d = 2'd0;
               end else begin
                  delay_d = delay_q + 3'd1;
               end
            end
            DMA_ACTIVE: begin
               phase_d = phase_q + 2'd1;
               // Source byte is captured on the edge that ends phase 1.
               if (phase_q == 2'd1) begin
                  buf_d = ext_rdata;
               end
               if (phase_q == 2'd3) begin
                  if (index_q == LAST_INDEX) begin
                     state_d = DMA_IDLE;
                  end else begin
                     index_d = index_q + 8'h01;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Output decode: phases 0/1 read the source, phase 2 writes OAM,
   // phase 3 is idle on the bus.
   always_comb begin
      dma_active   = (state_q == DMA_ACTIVE);
      dma_read_en  = dma_active && !phase_q[1];
      dma_write_en = dma_active && (phase_q == 2'd2);
      dma_addr     = phase_q[1] ? (OAM_BASE + {8'h00, index_q})
                                : {src_hi_map(dma_reg_q), index_q};
      dma_wdata    = buf_q;
      dma_reg      = dma_reg_q;
   end

endmodule

// File: rtl/oam_dma_arbiter.sv
// CPU/DMA arbiter for the main memory space plus the OAM DMA register.
//   clk, reset          : clock, synchronous active-low reset
//   cpu_*               : CPU bus (address, write data, strobes, read data)
//   ext_*               : main space 0x0000-0xFEFF, shared with the DMA engine
//   hi_*                : I/O + HRAM 0xFF00-0xFFFF (except 0xFF46), CPU only
//   dma_active          : high while the DMA owns the ext port
// All routing is combinational; the CPU sees read data in the same cycle.
module oam_dma_arbiter
   import oam_dma_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_read_en,
   input  logic        cpu_write_en,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] ext_addr,
   output logic [7:0]  ext_wdata,
   output logic        ext_read_en,
   output logic        ext_write_en,
   input  logic [7:0]  ext_rdata,
   output logic [15:0] hi_addr,
   output logic [7:0]  hi_wdata,
   output logic        hi_read_en,
   output logic        hi_write_en,
   input  logic [7:0]  hi_rdata,
   output logic        dma_active
);

   logic        reg_sel;
   logic        hi_sel;
   logic        main_sel;
   logic [7:0]  dma_reg;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_read_en;
   logic        dma_write_en;

   assign reg_sel  = (cpu_addr == DMA_REG_ADDR);
   assign hi_sel   = (cpu_addr >= HI_BASE) && !reg_sel;
   assign main_sel = (cpu_addr <  HI_BASE);

   oam_dma_engine u_engine (
      .clk          (clk),
      .reset        (reset),
      .cpu_write_en (cpu_write_en),
      .reg_sel      (reg_sel),
      .cpu_wdata    (cpu_wdata),
      .ext_rdata    (ext_rdata),
      .dma_reg      (dma_reg),
      .dma_active   (dma_active),
      .dma_addr     (dma_addr),
      .dma_wdata    (dma_wdata),
      .dma_read_en  (dma_read_en),
      .dma_write_en (dma_write_en)
   );

   always_comb begin
      // Hi port is CPU-only: address/data always mirror the CPU.
      hi_addr     = cpu_addr;
      hi_wdata    = cpu_wdata;
      hi_read_en  = hi_sel && cpu_read_en;
      hi_write_en = hi_sel && cpu_write_en;

      // Ext port belongs to the DMA for the whole ACTIVE state, including
      // phase 3 where it drives no strobe; CPU main-space traffic is dropped.
      if (dma_active) begin
         ext_addr     = dma_addr;
         ext_wdata    = dma_wdata;
         ext_read_en  = dma_read_en;
         ext_write_en = dma_write_en;
      end else begin
         ext_addr     = cpu_addr;
         ext_wdata    = cpu_wdata;
         ext_read_en  = main_sel && cpu_read_en;
         ext_write_en = main_sel && cpu_write_en;
      end

      // Blocked main-space reads float high, like an undriven bus.
      if (hi_sel) begin
         cpu_rdata = hi_rdata;
      end else if (reg_sel) begin
         cpu_rdata = dma_reg;
      end else if (dma_active) begin
         cpu_rdata = 8'hFF;
      end else begin
         cpu_rdata = ext_rdata;
      end
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed self-checking bench for oam_dma_arbiter. Main memory is a pure
// function of address; OAM writes are captured by a negedge monitor.
module tb_oam_dma_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_read_en;
   logic        cpu_write_en;
   logic [7:0]  cpu_rdata;
   logic [15:0] ext_addr;
   logic [7:0]  ext_wdata;
   logic        ext_read_en;
   logic        ext_write_en;
   logic [7:0]  ext_rdata;
   logic [15:0] hi_addr;
   logic [7:0]  hi_wdata;
   logic        hi_read_en;
   logic        hi_write_en;
   logic [7:0]  hi_rdata;
   logic        dma_active;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   oam_dma_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_read_en  (cpu_read_en),
      .cpu_write_en (cpu_write_en),
      .cpu_rdata    (cpu_rdata),
      .ext_addr     (ext_addr),
      .ext_wdata    (ext_wdata),
      .ext_read_en  (ext_read_en),
      .ext_write_en (ext_write_en),
      .ext_rdata    (ext_rdata),
      .hi_addr      (hi_addr),
      .hi_wdata     (hi_wdata),
      .hi_read_en   (hi_read_en),
      .hi_write_en  (hi_write_en),
      .hi_rdata     (hi_rdata),
      .dma_active   (dma_active)
   );

   // Page 0xC1 holds i^0x5A; every other page differs by a page-dependent mask.
   function automatic logic [7:0] mem_byte(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
   endfunction

   assign ext_rdata = mem_byte(ext_addr);
   assign hi_rdata  = hi_addr[7:0] ^ 8'hA5;

   // Monitor state (written only here).
   int          cyc = 0;
   int          active_cnt = 0;
   int          wr_cnt = 0;
   int          bad_rd = 0;
   int          bad_wr = 0;
   int          run_start_cyc = 0;
   logic [15:0] run_start_addr = 16'h0000;
   logic [15:0] last_rd_addr = 16'h0000;
   logic        prev_active = 1'b0;
   logic [7:0]  oam [160];
   logic [7:0]  exp_page = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_active <= (dma_active === 1'b1);
      if (dma_active === 1'b1) begin
         active_cnt <= active_cnt + 1;
         if (!prev_active) begin
            run_start_cyc  <= cyc;
            run_start_addr <= ext_addr;
         end
         if (ext_read_en === 1'b1) begin
            last_rd_addr <= ext_addr;
            if (ext_addr[15:8] !== exp_page) bad_rd <= bad_rd + 1;
         end
      end
      if (ext_write_en === 1'b1) begin
         wr_cnt <= wr_cnt + 1;
         if (ext_addr >= 16'hFE00 && ext_addr <= 16'hFE9F) oam[ext_addr[7:0]] <= ext_wdata;
         else bad_wr <= bad_wr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      cpu_read_en  = 1'b0;
      cpu_write_en = 1'b0;
   endtask

   int trig_cyc = 0;

   // Drives a write to FF46; returns #1 after the last edge of the strobe.
   task automatic trigger_dma(input logic [7:0] val, input int hold);
      cpu_addr     = 16'hFF46;
      cpu_wdata    = val;
      cpu_read_en  = 1'b0;
      cpu_write_en = 1'b1;
      @(posedge clk);
      #1;
      trig_cyc = cyc;
      for (int k = 1; k < hold; k++) tick();
      cpu_write_en = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 0;
      for (int n = 0; n < 900; n++) begin
         tick();
         if (dma_active === 1'b1) seen = 1;
         else if (seen) break;
      end
      check(tag, {30'd0, seen, dma_active}, 32'd2);
   endtask

   task automatic wait_active(input int base, input int n, input string tag);
      int k = 0;
      while ((active_cnt - base) < n && k < 900) begin
         tick();
         k++;
      end
      check(tag, ((active_cnt - base) >= n), 1);
   endtask

   function automatic int oam_mism(input logic [7:0] page);
      int m = 0;
      for (int i = 0; i < 160; i++)
         if (oam[i] !== mem_byte({page, 8'(i)})) m++;
      return m;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_act, b_wr, b_rd, b_wrbad, cnt;

      reset = 1'b0;
      cpu_addr = 16'h0000;
      cpu_wdata = 8'h00;
      cpu_idle();
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // 1: reset in the middle of a transfer from page 0x80
      trigger_dma(8'h80, 1);
      exp_page = 8'h80;
      b_act = active_cnt;
      wait_active(b_act, 50, "t1_reach_active");
      reset = 1'b0;
      cpu_addr = 16'hFF46;
      cpu_read_en = 1'b1;
      repeat (3) begin
         @(posedge clk);
      end
      @(negedge clk);
      check("t1_dma_active", dma_active, 0);
      check("t1_ext_read_en", ext_read_en, 0);
      check("t1_ext_write_en", ext_write_en, 0);
      check("t1_hi_read_en", hi_read_en, 0);
      check("t1_hi_write_en", hi_write_en, 0);
      check("t1_ff46_read", cpu_rdata, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cpu_idle();
      repeat (6) tick();
      check("t1_no_resume", dma_active, 0);

      // 2: page 0xC1 with the strobe held for two clocks
      trigger_dma(8'hC1, 2);
      exp_page = 8'hC1;
      b_act = active_cnt; b_wr = wr_cnt; b_rd = bad_rd; b_wrbad = bad_wr;
      repeat (12) tick();
      check("t2_first_read_latency", run_start_cyc - trig_cyc, 4);
      check("t2_first_read_addr", run_start_addr, 16'hC100);

      // 3: CPU traffic during ACTIVE
      cpu_addr = 16'hC000;
      cpu_read_en = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (cpu_rdata !== 8'hFF) cnt++;
      end
      check("t3_blocked_read_ff", cnt, 0);
      @(posedge clk); #1;
      cpu_read_en = 1'b0;
      cpu_wdata = 8'h55;
      cpu_write_en = 1'b1;
      repeat (4) tick();
      cpu_addr = 16'hFF80;
      cpu_wdata = 8'h33;
      @(negedge clk);
      check("t3_hi_write_en", hi_write_en, 1);
      check("t3_hi_wdata", hi_wdata, 8'h33);
      check("t3_hi_addr", hi_addr, 16'hFF80);
      @(posedge clk); #1;
      cpu_idle();

      wait_done("t2_done");
      check("t2_active_clocks", active_cnt - b_act, 640);
      check("t2_oam_writes", wr_cnt - b_wr, 160);
      check("t2_bad_src_reads", bad_rd - b_rd, 0);
      check("t2_bad_writes", bad_wr - b_wrbad, 0);
      check("t2_oam_first", oam[0], 8'h5A);
      check("t2_oam_last", oam[159], 8'hC5);
      check("t2_oam_all", oam_mism(8'hC1), 0);
      cpu_addr = 16'hFF46;
      cpu_read_en = 1'b1;
      @(negedge clk);
      check("t2_ff46_read", cpu_rdata, 8'hC1);
      @(posedge clk); #1;
      cpu_idle();

      // 4: echo-region source 0xE2 -> page 0xC2
      trigger_dma(8'hE2, 1);
      exp_page = 8'hC2;
      b_rd = bad_rd;
      wait_done("t4_done");
      check("t4_first_src", run_start_addr, 16'hC200);
      check("t4_last_src", last_rd_addr, 16'hC29F);
      check("t4_bad_src_reads", bad_rd - b_rd, 0);
      check("t4_oam_all", oam_mism(8'hC2), 0);
      cpu_addr = 16'hFF46;
      cpu_read_en = 1'b1;
      @(negedge clk);
      check("t4_ff46_read", cpu_rdata, 8'hE2);
      @(posedge clk); #1;
      cpu_idle();

      // 5: restart at byte 50
      trigger_dma(8'hC0, 1);
      exp_page = 8'hC0;
      b_act = active_cnt;
      wait_active(b_act, 202, "t5_reach_byte50");
      trigger_dma(8'hD0, 1);
      exp_page = 8'hD0;
      b_act = active_cnt; b_wr = wr_cnt; b_rd = bad_rd;
      wait_done("t5_done");
      check("t5_restart_latency", run_start_cyc - trig_cyc, 4);
      check("t5_first_src", run_start_addr, 16'hD000);
      check("t5_active_clocks", active_cnt - b_act, 640);
      check("t5_oam_writes", wr_cnt - b_wr, 160);
      check("t5_bad_src_reads", bad_rd - b_rd, 0);
      check("t5_oam_all", oam_mism(8'hD0), 0);

      // 6: IDLE routing
      cpu_addr = 16'h1234;
      cpu_read_en = 1'b1;
      @(negedge clk);
      check("t6_ext_addr", ext_addr, 16'h1234);
      check("t6_ext_read_en", ext_read_en, 1);
      check("t6_ext_rdata", cpu_rdata, mem_byte(16'h1234));
      check("t6_hi_idle", hi_read_en, 0);
      @(posedge clk); #1;
      cpu_addr = 16'hFF44;
      @(negedge clk);
      check("t6_hi_read_en", hi_read_en, 1);
      check("t6_hi_addr", hi_addr, 16'hFF44);
      check("t6_ext_idle", ext_read_en, 0);
      check("t6_hi_rdata", cpu_rdata, 8'hE1);
      @(posedge clk); #1;
      cpu_read_en = 1'b0;
      cpu_addr = 16'hC000;
      cpu_wdata = 8'h77;
      cpu_write_en = 1'b1;
      @(negedge clk);
      check("t6_ext_write_en", ext_write_en, 1);
      check("t6_ext_wdata", ext_wdata, 8'h77);
      @(posedge clk); #1;
      cpu_idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
